// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD controller: one byte per valid/ready transfer, with setup, enable-pulse and execution-wait timing.
// Define LCD_INIT_EN to build the power-on init sequence; without it the controller resets straight into IDLE.
module lcd_ctrl #(
  parameter int unsigned INIT_WAIT_CYC = 2_000_000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned PULSE_CYC     = 25,
  parameter int unsigned CMD_WAIT_CYC  = 2_000,
  parameter int unsigned CLR_WAIT_CYC  = 82_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  // A zero cycle count still means one cycle in the state
  localparam int unsigned INIT_W  = (INIT_WAIT_CYC == 0) ? 1 : INIT_WAIT_CYC;
  localparam int unsigned SETUP_W = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned PULSE_W = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
  localparam int unsigned CMD_W   = (CMD_WAIT_CYC == 0) ? 1 : CMD_WAIT_CYC;
  localparam int unsigned CLR_W   = (CLR_WAIT_CYC == 0) ? 1 : CLR_WAIT_CYC;

  localparam int unsigned MAX_A   = (INIT_W > SETUP_W) ? INIT_W : SETUP_W;
  localparam int unsigned MAX_B   = (MAX_A > PULSE_W) ? MAX_A : PULSE_W;
  localparam int unsigned MAX_C   = (MAX_B > CMD_W) ? MAX_B : CMD_W;
  localparam int unsigned MAX_CYC = (MAX_C > CLR_W) ? MAX_C : CLR_W;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_CMD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT
  } state_t;

`ifdef LCD_INIT_EN
  localparam state_t      RST_STATE = S_INIT_WAIT;
  localparam logic        RST_READY = 1'b0;
  localparam int unsigned IDX_LAST  = 5;

  logic [2:0] idx;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      default:          init_rom = 8'h06;
    endcase
  endfunction
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_READY = 1'b1;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_clr;

  // Clear display and return-home need the long execution wait
  assign is_clr = !o_lcd_rs && (o_lcd_data[7:2] == 6'b0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RST_STATE;
      o_ready     <= RST_READY;
      o_init_done <= RST_READY;
      o_lcd_on    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_data  <= 8'h00;
      cnt         <= '0;
`ifdef LCD_INIT_EN
      idx         <= '0;
`endif
    end else begin
      o_lcd_on <= 1'b1;
      o_lcd_rw <= 1'b0;
      if (cnt > CW'(1)) cnt <= cnt - CW'(1);

      case (state)
`ifdef LCD_INIT_EN
        // Counter comes out of reset at 0; the first cycle loads the power-on wait
        S_INIT_WAIT: begin
          if (cnt == '0) cnt <= CW'(INIT_W);
          else if (cnt == CW'(1)) state <= S_INIT_CMD;
        end
        S_INIT_CMD: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= init_rom(idx);
          cnt        <= CW'(SETUP_W);
          state      <= S_SETUP;
        end
`endif
        S_IDLE: begin
          if (i_valid) begin
            o_lcd_rs   <= i_rs;
            o_lcd_data <= i_data;
            o_ready    <= 1'b0;
            cnt        <= CW'(SETUP_W);
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(1)) begin
            o_lcd_en <= 1'b1;
            cnt      <= CW'(PULSE_W);
            state    <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (cnt == CW'(1)) begin
            o_lcd_en <= 1'b0;
            cnt      <= is_clr ? CW'(CLR_W) : CW'(CMD_W);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == CW'(1)) begin
`ifdef LCD_INIT_EN
            if (!o_init_done) begin
              if (idx == 3'(IDX_LAST)) begin
                o_init_done <= 1'b1;
                o_ready     <= 1'b1;
                state       <= S_IDLE;
              end else begin
                idx   <= idx + 3'd1;
                state <= S_INIT_CMD;
              end
            end else begin
              o_ready <= 1'b1;
              state   <= S_IDLE;
            end
`else
            o_ready <= 1'b1;
            state   <= S_IDLE;
`endif
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl; covers both the LCD_INIT_EN build and the plain build.
module tb_lcd_ctrl;

  localparam int unsigned P_INIT  = 10;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_PULSE = 3;
  localparam int unsigned P_CMD   = 5;
  localparam int unsigned P_CLR   = 20;

`ifdef LCD_INIT_EN
  localparam int RST_READY = 0;
`else
  localparam int RST_READY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_early = 0;

  int         rise_cyc[$];
  int         fall_cyc[$];
  logic [7:0] rise_data[$];
  logic       rise_rs[$];
  logic       en_q = 1'b0;

  lcd_ctrl #(
    .INIT_WAIT_CYC(P_INIT),
    .SETUP_CYC    (P_SETUP),
    .PULSE_CYC    (P_PULSE),
    .CMD_WAIT_CYC (P_CMD),
    .CLR_WAIT_CYC (P_CLR)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_rs       (rs),
    .i_data     (data),
    .o_ready    (ready),
    .o_init_done(init_done),
    .o_lcd_on   (lcd_on),
    .o_lcd_en   (lcd_en),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: cycle stamps are in posedges since time zero
  always @(negedge clk) begin
    if (lcd_en && !en_q) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(lcd_data);
      rise_rs.push_back(lcd_rs);
    end
    if (!lcd_en && en_q) fall_cyc.push_back(cyc);
    en_q = lcd_en;
    if (rst_n && ready && !init_done) ready_early++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    rise_cyc.delete();
    fall_cyc.delete();
    rise_data.delete();
    rise_rs.delete();
  endtask

  task automatic wait_ready(input int a, output int lat);
    int n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - a;
  endtask

  // One transfer; a = accept edge index, lat = cycles until o_ready is back
  task automatic send(input logic r, input logic [7:0] d, output int a, output int lat,
                      output logic [7:0] got_d, output logic got_r, output logic got_rdy);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    valid = 1'b1;
    rs    = r;
    data  = d;
    @(negedge clk);
    a       = cyc;
    got_d   = lcd_data;
    got_r   = lcd_rs;
    got_rdy = ready;
    valid   = 1'b0;
    wait_ready(a, lat);
  endtask

`ifdef LCD_INIT_EN
  // Waits for init to finish and checks the ROM pulses; i_valid is released when done rises
  task automatic check_init(input string pfx);
    int n = 0;
    int done_cyc;
    logic [7:0] rom [6];
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    valid    = 1'b0;
    done_cyc = cyc;
    chk({pfx, "_done"}, int'(init_done), 1);
    chk({pfx, "_ready_with_done"}, int'(ready), 1);
    chk({pfx, "_pulse_count"}, rise_cyc.size(), 6);
    if (rise_cyc.size() == 6 && fall_cyc.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("%s_data%0d", pfx, k), int'(rise_data[k]), int'(rom[k]));
        chk($sformatf("%s_rs%0d", pfx, k), int'(rise_rs[k]), 0);
        chk($sformatf("%s_width%0d", pfx, k), fall_cyc[k] - rise_cyc[k], P_PULSE);
      end
      // Fall-to-rise = wait + one INIT_CMD cycle + setup
      chk({pfx, "_gap_0c"}, rise_cyc[4] - fall_cyc[3], P_CMD + 1 + P_SETUP);
      chk({pfx, "_gap_01"}, rise_cyc[5] - fall_cyc[4], P_CLR + 1 + P_SETUP);
      chk({pfx, "_last_wait"}, done_cyc - fall_cyc[5], P_CMD);
    end
  endtask
`endif

  initial begin
    int a, lat, acc, bidx, n;
    logic [7:0] gd;
    logic gr, grdy, prev_acc;
    logic [7:0] seq [2];
    logic [7:0] cmd_d [5];
    logic       cmd_r [5];
    int         cmd_l [5];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), RST_READY);
    chk("rst_init_done", int'(init_done), RST_READY);
    chk("rst_lcd_on", int'(lcd_on), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_data", int'(lcd_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lcd_on_after_rst", int'(lcd_on), 1);

`ifdef LCD_INIT_EN
    check_init("init");
`else
    chk("noinit_ready", int'(ready), 1);
    chk("noinit_done", int'(init_done), 1);
    repeat (10) @(negedge clk);
    chk("noinit_no_pulse", rise_cyc.size(), 0);
`endif

    // Data write
    clear_q();
    send(1'b1, 8'h41, a, lat, gd, gr, grdy);
    chk("wr_data", int'(gd), 'h41);
    chk("wr_rs", int'(gr), 1);
    chk("wr_ready_low", int'(grdy), 0);
    chk("wr_latency", lat, P_SETUP + P_PULSE + P_CMD);
    chk("wr_pulse_count", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1 && fall_cyc.size() == 1) begin
      chk("wr_en_rise", rise_cyc[0] - a, P_SETUP);
      chk("wr_en_width", fall_cyc[0] - rise_cyc[0], P_PULSE);
      chk("wr_rw", int'(lcd_rw), 0);
    end

    // Clear/home detection boundaries: RS=0 and data[7:2]==0 only
    cmd_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmd_d = '{8'h01, 8'h80, 8'h03, 8'h04, 8'h01};
    cmd_l = '{25, 10, 25, 10, 10};
    for (int k = 0; k < 5; k++) begin
      send(cmd_r[k], cmd_d[k], a, lat, gd, gr, grdy);
      chk($sformatf("cmd%0d_latency", k), lat, cmd_l[k]);
      chk($sformatf("cmd%0d_data", k), int'(gd), int'(cmd_d[k]));
    end

    // Busy hold: producer keeps i_valid high and advances only on accept
    clear_q();
    @(negedge clk);
    seq      = '{8'h42, 8'h43};
    bidx     = 0;
    acc      = 0;
    valid    = 1'b1;
    rs       = 1'b1;
    data     = seq[0];
    prev_acc = ready && valid;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (prev_acc) begin
        bidx++;
        acc++;
      end
      if (bidx >= 2) valid = 1'b0;
      else data = seq[bidx];
      prev_acc = ready && valid;
    end
    valid = 1'b0;
    wait_ready(cyc, lat);
    chk("busy_accepts", acc, 2);
    chk("busy_pulse_count", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      chk("busy_data0", int'(rise_data[0]), 'h42);
      chk("busy_data1", int'(rise_data[1]), 'h43);
      // Ten-cycle transfer plus the one IDLE cycle in which the next accept happens
      chk("busy_spacing", rise_cyc[1] - rise_cyc[0], P_SETUP + P_PULSE + P_CMD + 1);
    end

    // Reset while EN is high
    @(negedge clk);
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h55;
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
      if (!ready) valid = 1'b0;
    end
    valid = 1'b0;
    chk("mid_en_seen", int'(lcd_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", int'(lcd_en), 0);
    chk("mid_rst_data", int'(lcd_data), 0);
    chk("mid_rst_ready", int'(ready), RST_READY);
    @(negedge clk);
`ifdef LCD_INIT_EN
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'hAA;
`endif
    rst_n = 1'b1;
    clear_q();
`ifdef LCD_INIT_EN
    check_init("reinit");
    chk("ready_before_init", ready_early, 0);
`else
    @(negedge clk);
    chk("mid_noinit_ready", int'(ready), 1);
    chk("mid_noinit_done", int'(init_done), 1);
    repeat (10) @(negedge clk);
    chk("mid_noinit_no_pulse", rise_cyc.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
